// File: rtl/disp_pkg.sv
// Shared types and helpers for the N-lane serial dispatcher.
//   lane_state_t : per-lane alignment FSM states (SEARCH, SYNC, ACTIVE)
//   DEF_COM      : default alignment/idle symbol
//   cnt_w()      : width helper for pointers and counters (never below 1)
package disp_pkg;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      SYNC   = 2'd1,
      ACTIVE = 2'd2
   } lane_state_t;

   localparam logic [7:0] DEF_COM = 8'hBC;

   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/disp_lane.sv
// One dispatcher lane: serial-to-symbol deserialiser, COM alignment FSM and
// a DEPTH-entry symbol FIFO with status flags.
//   clk, reset    : clock, asynchronous active-high reset
//   serial_in     : lane serial bit, MSB of each symbol first
//   read          : pop request from the switch logic
//   push_en       : allows data symbols into the FIFO (deskew gating in top)
//   data_out      : popped symbol, held until the next pop
//   valid_out     : one-cycle pulse, data_out carries a freshly popped symbol
//   active        : lane is aligned (state ACTIVE)
//   empty / almost_full / almost_empty : FIFO occupancy flags
//   overflow      : sticky, a data symbol was dropped because the FIFO was full
//   state_dbg     : current FSM state
//
// Read handshake: read is a request with no ready return; it is honoured on
// a clock edge only when the FIFO holds at least one entry before that edge.
// An honoured read produces valid_out=1 with the symbol on data_out in the
// following cycle; a read on an empty FIFO is dropped silently.
module disp_lane
   import disp_pkg::*;
#(
   parameter int             W         = 8,
   parameter int             DEPTH     = 8,
   parameter logic [W-1:0]   COM       = W'(DEF_COM),
   parameter int             COM_LOCK  = 4,
   parameter int             AF_THRESH = 6,
   parameter int             AE_THRESH = 2
)(
   input  logic         clk,
   input  logic         reset,
   input  logic         serial_in,
   input  logic         read,
   input  logic         push_en,
   output logic [W-1:0] data_out,
   output logic         valid_out,
   output logic         active,
   output logic         empty,
   output logic         almost_full,
   output logic         almost_empty,
   output logic         overflow,
   output logic [1:0]   state_dbg
);

   localparam int PW = cnt_w(DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = cnt_w(W);
   localparam int KW = cnt_w(COM_LOCK + 1);

   // Only the W-1 older bits need storing; the newest bit comes from serial_in.
   logic [W-2:0]  hist_q;
   logic [W-1:0]  shift_next;
   lane_state_t   state_q, state_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [KW-1:0] com_cnt_q, com_cnt_d;
   logic          is_com, boundary, push_req;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          full, do_pop, do_write, ovf_hit;

   assign shift_next = {hist_q, serial_in};
   assign is_com     = (shift_next == COM);
   // bit_cnt is zeroed on the edge that completes a symbol, so the next
   // symbol completes W edges later when it reaches W-1.
   assign boundary   = (bit_cnt_q == BW'(W - 1));

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = boundary ? '0 : bit_cnt_q + BW'(1);
      com_cnt_d = com_cnt_q;
      push_req  = 1'b0;
      case (state_q)
         SEARCH: begin
            bit_cnt_d = '0;
            if (is_com) begin
               state_d   = SYNC;
               com_cnt_d = KW'(1);
            end
         end
         SYNC: begin
            if (boundary) begin
               if (is_com) begin
                  com_cnt_d = com_cnt_q + KW'(1);
                  if (com_cnt_d == KW'(COM_LOCK)) state_d = ACTIVE;
               end else begin
                  state_d   = SEARCH;
                  com_cnt_d = '0;
               end
            end
         end
         ACTIVE: begin
            // Idle COMs are dropped; the lane never leaves ACTIVE until reset.
            if (boundary && !is_com) push_req = 1'b1;
         end
         default: state_d = SEARCH;
      endcase
   end

   assign full     = (count == CW'(DEPTH));
   assign do_pop   = read && (count != '0);
   // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
   assign do_write = push_req && push_en && (!full || do_pop);
   assign ovf_hit  = push_req && push_en && full && !do_pop;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q    <= '0;
         state_q   <= SEARCH;
         bit_cnt_q <= '0;
         com_cnt_q <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         data_out  <= '0;
         valid_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         hist_q    <= shift_next[W-2:0];
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         com_cnt_q <= com_cnt_d;
         valid_out <= do_pop;
         if (do_pop) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + PW'(1);
         end
         if (do_write) wr_ptr <= wr_ptr + PW'(1);
         if (do_write && !do_pop)      count <= count + CW'(1);
         else if (!do_write && do_pop) count <= count - CW'(1);
         if (ovf_hit) overflow <= 1'b1;
      end
   end

   // Storage carries no reset; occupancy is tracked by count and pointers.
   always_ff @(posedge clk) begin
      if (do_write) mem[wr_ptr] <= shift_next;
   end

   assign active       = (state_q == ACTIVE);
   assign empty        = (count == '0);
   assign almost_full  = (count >= CW'(AF_THRESH));
   assign almost_empty = (count <= CW'(AE_THRESH));
   assign state_dbg    = state_q;

endmodule

// File: rtl/disp_nlane.sv
// N-lane serial dispatcher: LANES independent deserialising lanes, each with
// COM alignment and its own symbol FIFO read by the downstream switch.
//   clk, reset    : clock, asynchronous active-high reset
//   serial_in[i]  : lane i serial data
//   read[i]       : lane i pop request
//   data_out      : lane i symbol at [i*W +: W]
//   valid_out[i]  : lane i data_out refreshed this cycle
//   active[i]     : lane i aligned
//   empty, almost_full, almost_empty, overflow : per-lane FIFO flags
//   state_dbg     : lane i FSM state at [2*i +: 2]
// Optional macro DISP_DESKEW_EN: lanes report active only once all lanes are
// aligned, data pushes wait for that point, and reads are honoured only
// when no lane is empty, so all lanes pop in lockstep.
module disp_nlane
   import disp_pkg::*;
#(
   parameter int           LANES     = 4,
   parameter int           W         = 8,
   parameter int           DEPTH     = 8,
   parameter logic [W-1:0] COM       = W'(DEF_COM),
   parameter int           COM_LOCK  = 4,
   parameter int           AF_THRESH = 6,
   parameter int           AE_THRESH = 2
)(
   input  logic               clk,
   input  logic               reset,
   input  logic [LANES-1:0]   serial_in,
   input  logic [LANES-1:0]   read,
   output logic [LANES*W-1:0] data_out,
   output logic [LANES-1:0]   valid_out,
   output logic [LANES-1:0]   active,
   output logic [LANES-1:0]   empty,
   output logic [LANES-1:0]   almost_full,
   output logic [LANES-1:0]   almost_empty,
   output logic [LANES-1:0]   overflow,
   output logic [2*LANES-1:0] state_dbg
);

   logic [LANES-1:0] lane_active, push_en, rd_eff;

`ifdef DISP_DESKEW_EN
   logic all_active;
   assign all_active = &lane_active;
   assign push_en    = {LANES{all_active}};
   assign active     = {LANES{all_active}};
   // Before global lock every FIFO is empty, so this gate covers that too.
   assign rd_eff     = (|empty) ? '0 : read;
`else
   assign push_en    = '1;
   assign active     = lane_active;
   assign rd_eff     = read;
`endif

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      disp_lane #(
         .W(W), .DEPTH(DEPTH), .COM(COM), .COM_LOCK(COM_LOCK),
         .AF_THRESH(AF_THRESH), .AE_THRESH(AE_THRESH)
      ) u_lane (
         .clk          (clk),
         .reset        (reset),
         .serial_in    (serial_in[i]),
         .read         (rd_eff[i]),
         .push_en      (push_en[i]),
         .data_out     (data_out[i*W +: W]),
         .valid_out    (valid_out[i]),
         .active       (lane_active[i]),
         .empty        (empty[i]),
         .almost_full  (almost_full[i]),
         .almost_empty (almost_empty[i]),
         .overflow     (overflow[i]),
         .state_dbg    (state_dbg[2*i +: 2])
      );
   end

endmodule

// File: tb/tb_disp_nlane.sv
// Bench for disp_nlane: directed phases plus a randomized phase, every cycle
// checked against a stream-level reference model (bit history per lane,
// lock found by scanning the history for COM_LOCK COMs at symbol spacing,
// FIFO contents as queues).
module tb_disp_nlane;
   import disp_pkg::*;

   localparam int           LANES    = 4;
   localparam int           W        = 8;
   localparam int           DEPTH    = 8;
   localparam int           COM_LOCK = 4;
   localparam int           AF       = 6;
   localparam int           AE       = 2;
   localparam logic [W-1:0] COM      = 8'hBC;

   // ---------------- clock / reset / DUT ----------------
   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [LANES-1:0]   serial_in = '0;
   logic [LANES-1:0]   read = '0;
   logic [LANES*W-1:0] data_out;
   logic [LANES-1:0]   valid_out, active, empty, almost_full, almost_empty, overflow;
   logic [2*LANES-1:0] state_dbg;

   always #5 clk = ~clk;

   disp_nlane #(
      .LANES(LANES), .W(W), .DEPTH(DEPTH), .COM(COM), .COM_LOCK(COM_LOCK),
      .AF_THRESH(AF), .AE_THRESH(AE)
   ) dut (
      .clk(clk), .reset(reset), .serial_in(serial_in), .read(read),
      .data_out(data_out), .valid_out(valid_out), .active(active),
      .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .overflow(overflow), .state_dbg(state_dbg)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model state ----------------
   int           n_checks = 0;
   int           n_fail   = 0;
   int           hist[LANES][$];        // every bit sampled since reset
   int           tx_q[LANES][$];        // bits still to be driven
   bit           fill_com[LANES];       // idle filler: COM symbol or a single 0 bit
   int           lock_e[LANES];         // edge index where lane locked, -1 if not
   logic [W-1:0] exp_q[LANES][$];       // expected FIFO contents
   logic [W-1:0] exp_data[LANES];
   bit           exp_valid[LANES];
   bit           exp_ovf[LANES];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Symbol formed by the W most recent bits up to and including edge e.
   function automatic logic [W-1:0] sym_at(input int l, input int e);
      logic [W-1:0] s;
      int idx;
      s = '0;
      for (int j = 0; j < W; j++) begin
         idx = e - (W - 1) + j;
         s[W-1-j] = (idx >= 0) && (hist[l][idx] != 0);
      end
      return s;
   endfunction

   // Scan the history: a COM anywhere starts a candidate; it locks once
   // COM_LOCK COMs sit W bits apart; a non-COM at that spacing restarts the
   // search on the following bit.
   function automatic int find_lock(input int l);
      int n, e, k;
      n = hist[l].size();
      e = 0;
      while (e < n) begin
         if (sym_at(l, e) == COM) begin
            k = 1;
            while (k < COM_LOCK && e + k*W < n && sym_at(l, e + k*W) == COM) k++;
            if (k == COM_LOCK) return e + (COM_LOCK - 1) * W;
            if (e + k*W >= n) return -1;
            e = e + k*W + 1;
         end else begin
            e++;
         end
      end
      return -1;
   endfunction

   function automatic bit glob_lock();
      bit g;
      g = 1'b1;
      for (int l = 0; l < LANES; l++) if (lock_e[l] < 0) g = 1'b0;
      return g;
   endfunction

   task automatic model_reset();
      for (int l = 0; l < LANES; l++) begin
         hist[l].delete();
         tx_q[l].delete();
         exp_q[l].delete();
         lock_e[l]    = -1;
         fill_com[l]  = 1'b0;
         exp_data[l]  = '0;
         exp_valid[l] = 1'b0;
         exp_ovf[l]   = 1'b0;
      end
   endtask

   // ---------------- scoreboard compare ----------------
   task automatic check_all();
      logic [LANES*W-1:0] e_data;
      logic [LANES-1:0]   e_val, e_act, e_emp, e_af, e_ae, e_ovf;
      for (int l = 0; l < LANES; l++) begin
         e_data[l*W +: W] = exp_data[l];
         e_val[l] = exp_valid[l];
`ifdef DISP_DESKEW_EN
         e_act[l] = glob_lock();
`else
         e_act[l] = (lock_e[l] >= 0);
`endif
         e_emp[l] = (exp_q[l].size() == 0);
         e_af[l]  = (exp_q[l].size() >= AF);
         e_ae[l]  = (exp_q[l].size() <= AE);
         e_ovf[l] = exp_ovf[l];
      end
      chk("data_out",     64'(data_out),     64'(e_data));
      chk("valid_out",    64'(valid_out),    64'(e_val));
      chk("active",       64'(active),       64'(e_act));
      chk("empty",        64'(empty),        64'(e_emp));
      chk("almost_full",  64'(almost_full),  64'(e_af));
      chk("almost_empty", 64'(almost_empty), 64'(e_ae));
      chk("overflow",     64'(overflow),     64'(e_ovf));
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_sym(input int l, input logic [W-1:0] v);
      for (int j = W - 1; j >= 0; j--) tx_q[l].push_back(int'(v[j]));
   endtask

   task automatic send_bits(input int l, input logic [31:0] v, input int n);
      for (int j = n - 1; j >= 0; j--) tx_q[l].push_back(int'(v[j]));
   endtask

   function automatic logic [W-1:0] rand_data();
      logic [W-1:0] v;
      do v = W'($urandom_range(0, 255)); while (v == COM);
      return v;
   endfunction

   // One clock: drive a bit per lane plus read, advance the model, check.
   task automatic step(input logic [LANES-1:0] rd);
      logic [LANES-1:0] sbit, eff_rd;
      logic [W-1:0]     s;
      bit               lk_before, gate, any_empty;
      int               e;
      e = hist[0].size();
      for (int l = 0; l < LANES; l++) begin
         if (tx_q[l].size() == 0) begin
            if (fill_com[l]) send_sym(l, COM);
            else             tx_q[l].push_back(0);
         end
         sbit[l] = (tx_q[l].pop_front() != 0);
      end
      serial_in = sbit;
      read      = rd;
      gate      = 1'b1;
      any_empty = 1'b0;
      for (int l = 0; l < LANES; l++) if (exp_q[l].size() == 0) any_empty = 1'b1;
      eff_rd = rd;
`ifdef DISP_DESKEW_EN
      gate = glob_lock();
      if (any_empty) eff_rd = '0;
`endif
      for (int l = 0; l < LANES; l++) begin
         lk_before = (lock_e[l] >= 0);
         hist[l].push_back(int'(sbit[l]));
         if (!lk_before) lock_e[l] = find_lock(l);
         exp_valid[l] = 1'b0;
         if (eff_rd[l] && exp_q[l].size() > 0) begin
            exp_data[l]  = exp_q[l].pop_front();
            exp_valid[l] = 1'b1;
         end
         s = sym_at(l, e);
         if (lk_before && gate && ((e - lock_e[l]) % W == 0) && s != COM) begin
            if (exp_q[l].size() < DEPTH) exp_q[l].push_back(s);
            else                         exp_ovf[l] = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic run(input int n, input logic [LANES-1:0] rd);
      for (int k = 0; k < n; k++) step(rd);
   endtask

   task automatic wait_idle(input int l);
      int k;
      k = 0;
      while (tx_q[l].size() != 0 && k < 200) begin
         step('0);
         k++;
      end
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      serial_in = '0;
      read      = '0;
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      chk("state_dbg_reset", 64'(state_dbg), 64'({LANES{SEARCH}}));
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [W-1:0]     first;
      logic [LANES-1:0] rd;
      int               zt[4] = '{8, 20, 29, 38};

      do_reset();

`ifdef DISP_DESKEW_EN
      // Staggered locks after 40/52/61/70 cycles; active rises only at 70.
      for (int l = 0; l < LANES; l++) begin
         fill_com[l] = 1'b1;
         for (int j = 0; j < zt[l % 4]; j++) tx_q[l].push_back(0);
         for (int k = 0; k < COM_LOCK; k++) send_sym(l, COM);
      end
      run(69, '0);
      chk("deskew_hold", 64'(active), 64'(0));
      step('0);
      chk("deskew_all", 64'(active), 64'({LANES{1'b1}}));
`else
      // Lane 0: lock then two data symbols, read back in order.
      fill_com[0] = 1'b1;
      for (int k = 0; k < COM_LOCK; k++) send_sym(0, COM);
      send_sym(0, 8'h3C);
      send_sym(0, 8'h5A);
      run(COM_LOCK * W - 1, '0);
      chk("act0_before_lock", 64'(active[0]), 64'(0));
      step('0);
      chk("act0_lock", 64'(active[0]), 64'(1));
      run(2 * W, '0);
      chk("empty0_two_pushed", 64'(empty[0]), 64'(0));
      step(4'b0001);
      chk("rd0_valid_a", 64'(valid_out[0]), 64'(1));
      chk("rd0_data_a", 64'(data_out[7:0]), 64'(8'h3C));
      step(4'b0001);
      chk("rd0_data_b", 64'(data_out[7:0]), 64'(8'h5A));
      step('0);
      chk("rd0_valid_idle", 64'(valid_out[0]), 64'(0));
      chk("empty0_drained", 64'(empty[0]), 64'(1));

      // Lane 1: shifted COM, another COM, then a non-COM -> stays unaligned.
      // Lane 2: shifted COM followed by a full lock run -> aligns.
      send_bits(1, 32'b101, 3);
      send_sym(1, COM);
      send_sym(1, COM);
      send_sym(1, 8'h55);
      fill_com[2] = 1'b1;
      send_bits(2, 32'b101, 3);
      for (int k = 0; k < COM_LOCK; k++) send_sym(2, COM);
      run(3 + COM_LOCK * W + 4, '0);
      chk("act1_sync_broken", 64'(active[1]), 64'(0));
      chk("act2_shifted_lock", 64'(active[2]), 64'(1));

      // Lane 0: nine pushes into eight entries, then read back eight.
      for (int k = 0; k < 9; k++) begin
         logic [W-1:0] v;
         v = rand_data();
         if (k == 0) first = v;
         send_sym(0, v);
      end
      run(10 * W, '0);
      chk("ovf0_set", 64'(overflow[0]), 64'(1));
      chk("af0_full", 64'(almost_full[0]), 64'(1));
      step(4'b0001);
      chk("ovf0_first_out", 64'(data_out[7:0]), 64'(first));
      run(DEPTH - 1, 4'b0001);
      step('0);
      chk("empty0_after_8", 64'(empty[0]), 64'(1));
      chk("ovf0_sticky", 64'(overflow[0]), 64'(1));

      // Lane 2: fill to DEPTH, then push and read on the same edge.
      wait_idle(2);
      for (int k = 0; k < DEPTH; k++) send_sym(2, rand_data());
      wait_idle(2);
      chk("af2_full", 64'(almost_full[2]), 64'(1));
      send_sym(2, rand_data());
      run(W - 1, '0);
      step(4'b0100);
      chk("full_rw_valid", 64'(valid_out[2]), 64'(1));
      chk("full_rw_ovf", 64'(overflow[2]), 64'(0));
      chk("full_rw_af", 64'(almost_full[2]), 64'(1));
      run(DEPTH + 2, 4'b0100);
      chk("rd_empty_valid", 64'(valid_out[2]), 64'(0));
      chk("rd_empty_flag", 64'(empty[2]), 64'(1));
`endif

      // Random phase: random data/COM mix on aligned lanes, random noise on
      // lane 1, random reads (sparse first half, dense second half).
      if (lock_e[3] < 0) begin
         fill_com[3] = 1'b1;
         for (int k = 0; k < COM_LOCK; k++) send_sym(3, COM);
      end
      for (int c = 0; c < 400; c++) begin
         for (int l = 0; l < LANES; l++) begin
            if (tx_q[l].size() == 0) begin
               if (l == 1) begin
                  send_bits(1, 32'($urandom_range(0, 255)), W);
               end else if (lock_e[l] >= 0 && $urandom_range(0, 3) != 0) begin
                  if ($urandom_range(0, 4) == 0) send_sym(l, COM);
                  else                           send_sym(l, W'($urandom_range(0, 255)));
               end
            end
            rd[l] = ($urandom_range(0, 3) < ((c < 200) ? 1 : 3));
         end
         step(rd);
      end

`ifndef DISP_DESKEW_EN
      // Reset while lane 0 holds five entries.
      do_reset();
      fill_com[0] = 1'b1;
      for (int k = 0; k < COM_LOCK; k++) send_sym(0, COM);
      for (int k = 0; k < 5; k++) send_sym(0, rand_data());
      wait_idle(0);
      chk("five_empty", 64'(empty[0]), 64'(0));
      chk("five_ae", 64'(almost_empty[0]), 64'(0));
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check_all();
      chk("midreset_state", 64'(state_dbg), 64'({LANES{SEARCH}}));
      @(posedge clk);
      #1;
      reset = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
